// File: rtl/fir_coeff_loader_pkg.sv
// -----------------------------------------------------------------------------
// fir_coeff_loader_pkg
//   Shared definitions for the FIR coefficient loader and its neighbours.
//   - state_t : loader FSM encoding, also exported on the loader's debug port
//   - n_ld()  : number of coefficients actually downloaded (symmetric first
//               half, rounded up to whole polyphase rows of M taps)
//   - gap_w() : width of the inter-write gap counter for a given WR_GAP
// -----------------------------------------------------------------------------
package fir_coeff_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_GAP   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

  // Coefficients loaded for a filter of order ord with m polyphase branches:
  // half of the per-branch rows (rounded up), times the branch count.
  function automatic int n_ld(input int ord, input int m);
    return (((ord + 1) / m + 1) / 2) * m;
  endfunction

  // The gap counter only has to hold wr_gap-1; keep at least one bit so the
  // timer still elaborates when gaps are disabled.
  function automatic int gap_w(input int wr_gap);
    if (wr_gap <= 1) return 1;
    return $clog2(wr_gap);
  endfunction

endpackage

// File: rtl/fir_coeff_loader_if.sv
// -----------------------------------------------------------------------------
// fir_coeff_loader_if
//   Coefficient stream into the loader.
//
//   Handshake: a word transfers on every rising clk edge where s_valid and
//   s_ready are both high. The source holds s_data/s_last stable while s_valid
//   is high and s_ready is low; s_ready may change freely and never depends
//   combinationally on s_valid.
//
//   Signals: s_valid, s_data[COEFF_SIZE], s_last (source -> loader),
//            s_ready (loader -> source).
//   Modports: master = stream source, slave = loader.
// -----------------------------------------------------------------------------
interface fir_coeff_loader_if #(
  parameter int COEFF_SIZE = 16
) ();

  logic                  s_valid;
  logic                  s_ready;
  logic [COEFF_SIZE-1:0] s_data;
  logic                  s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/fir_coeff_loader_gap_timer.sv
// -----------------------------------------------------------------------------
// fir_coeff_loader_gap_timer
//   Down-counter that paces idle cycles between coefficient writes.
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     load       load load_val (wins over en)
//     en         decrement by one while non-zero
//     load_val   reload value (number of remaining gap cycles minus one)
//     zero       count is zero
// -----------------------------------------------------------------------------
module fir_coeff_loader_gap_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/fir_coeff_loader.sv
// -----------------------------------------------------------------------------
// fir_coeff_loader
//   Downloads the symmetric first half of a polyphase FIR coefficient set from
//   a valid/ready stream into the decimator's coefficient port, holding the
//   decimator in load mode for the whole transfer, checking the stream length
//   and reporting done/err plus a wrapping checksum of the written words.
//
//   Ports:
//     clk, rst     single clock, synchronous active-high reset
//     start        1-cycle pulse; begins a load from IDLE or DONE
//     abort        terminates any non-IDLE activity, beats every other input
//     s            coefficient stream (slave side)
//     c_we         decimator load mode, high in LOAD, GAP and FLUSH
//     c_wr         one-cycle strobe per coefficient written
//     c_in/c_addr  registered coefficient and address, held when c_wr=0
//     busy         high in LOAD, GAP and FLUSH
//     done, err    sticky status, cleared by the next accepted start
//     checksum     modulo 2^COEFF_SIZE sum of written coefficients
//     state_o      current FSM state (debug)
// -----------------------------------------------------------------------------
module fir_coeff_loader
  import fir_coeff_loader_pkg::*;
#(
  parameter  int ORD        = 255,
  parameter  int M          = 8,
  parameter  int COEFF_SIZE = 16,
  parameter  int WR_GAP     = 0,
  localparam int N_LD       = n_ld(ORD, M),
  localparam int AW         = $clog2(ORD + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  fir_coeff_loader_if.slave     s,
  output logic                  c_we,
  output logic                  c_wr,
  output logic [COEFF_SIZE-1:0] c_in,
  output logic [AW-1:0]         c_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [COEFF_SIZE-1:0] checksum,
  output state_t                state_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(N_LD - 1);
  localparam int            GW        = gap_w(WR_GAP);
  localparam logic [GW-1:0] GAP_LOAD  = (WR_GAP > 0) ? GW'(WR_GAP - 1) : '0;

  state_t                state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic [AW-1:0]         c_addr_q, c_addr_d;
  logic [COEFF_SIZE-1:0] c_in_q, c_in_d;
  logic [COEFF_SIZE-1:0] checksum_q, checksum_d;
  logic                  c_wr_q, c_wr_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  drain_pend_q, drain_pend_d;

  logic s_ready_w;
  logic accept;
  logic gap_load;
  logic gap_zero;

  fir_coeff_loader_gap_timer #(
    .W (GW)
  ) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .en       (state_q == ST_GAP),
    .load_val (GAP_LOAD),
    .zero     (gap_zero)
  );

  // Ready is a pure function of state. A word offered in an abort cycle is
  // not taken, so it is never written nor counted.
  assign s_ready_w = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign accept    = s.s_valid && s_ready_w && !abort;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    c_addr_d     = c_addr_q;
    c_in_d       = c_in_q;
    checksum_d   = checksum_q;
    c_wr_d       = 1'b0;
    done_d       = done_q;
    err_d        = err_q;
    drain_pend_d = drain_pend_q;
    gap_load     = 1'b0;

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          // In IDLE an abort arriving with start still suppresses the start.
          if (start && !abort) begin
            state_d      = ST_LOAD;
            done_d       = 1'b0;
            err_d        = 1'b0;
            checksum_d   = '0;
            cnt_d        = '0;
            drain_pend_d = 1'b0;
          end
        end

        ST_LOAD: begin
          if (accept) begin
            c_wr_d     = 1'b1;
            c_in_d     = s.s_data;
            c_addr_d   = cnt_q;
            checksum_d = checksum_q + s.s_data;
            if (s.s_last) begin
              // Short stream still writes what it got, but flags an error.
              state_d = ST_FLUSH;
              if (cnt_q != LAST_ADDR) err_d = 1'b1;
            end else if (cnt_q == LAST_ADDR) begin
              // Stream is longer than the table: write the final slot, then
              // swallow the remainder up to s_last.
              state_d      = ST_FLUSH;
              err_d        = 1'b1;
              drain_pend_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
              if (WR_GAP > 0) begin
                state_d  = ST_GAP;
                gap_load = 1'b1;
              end
            end
          end
        end

        ST_GAP: begin
          if (gap_zero) state_d = ST_LOAD;
        end

        // FLUSH is entered while the final write strobe is on the port and
        // is held one further cycle so c_we covers the memory write; c_we
        // therefore falls two cycles after the final c_wr.
        ST_FLUSH: begin
          if (!c_wr_q) begin
            if (drain_pend_q) begin
              state_d = ST_DRAIN;
            end else if (err_q) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end

        ST_DRAIN: begin
          if (accept && s.s_last) begin
            state_d      = ST_IDLE;
            drain_pend_d = 1'b0;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      c_addr_q     <= '0;
      c_in_q       <= '0;
      checksum_q   <= '0;
      c_wr_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      drain_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      c_addr_q     <= c_addr_d;
      c_in_q       <= c_in_d;
      checksum_q   <= checksum_d;
      c_wr_q       <= c_wr_d;
      done_q       <= done_d;
      err_q        <= err_d;
      drain_pend_q <= drain_pend_d;
    end
  end

  assign s.s_ready = s_ready_w;
  assign c_we      = (state_q == ST_LOAD) || (state_q == ST_GAP) || (state_q == ST_FLUSH);
  assign busy      = c_we;
  assign c_wr      = c_wr_q;
  assign c_in      = c_in_q;
  assign c_addr    = c_addr_q;
  assign done      = done_q;
  assign err       = err_q;
  assign checksum  = checksum_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// -----------------------------------------------------------------------------
// tb_fir_coeff_loader
//   Bench for fir_coeff_loader. Instance a: ORD=255, M=8, WR_GAP=0.
//   Instance b: same filter with WR_GAP=3. Expected writes {addr,data} are
//   queued when a word is offered to a ready loader and popped by a monitor
//   whenever c_wr is seen.
// -----------------------------------------------------------------------------
module tb_fir_coeff_loader;
  import fir_coeff_loader_pkg::*;

  localparam int CW = 16;
  localparam int AW = 8;
  localparam int NL = 128;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic a_start = 1'b0, a_abort = 1'b0;
  logic b_start = 1'b0, b_abort = 1'b0;

  fir_coeff_loader_if #(.COEFF_SIZE(CW)) ifa ();
  fir_coeff_loader_if #(.COEFF_SIZE(CW)) ifb ();

  logic          a_we, a_wr, a_busy, a_done, a_err;
  logic [CW-1:0] a_cin, a_sum;
  logic [AW-1:0] a_addr;
  state_t        a_st;
  logic          b_we, b_wr, b_busy, b_done, b_err;
  logic [CW-1:0] b_cin, b_sum;
  logic [AW-1:0] b_addr;
  state_t        b_st;

  fir_coeff_loader #(.ORD(255), .M(8), .COEFF_SIZE(CW), .WR_GAP(0)) u_dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .s(ifa),
    .c_we(a_we), .c_wr(a_wr), .c_in(a_cin), .c_addr(a_addr), .busy(a_busy),
    .done(a_done), .err(a_err), .checksum(a_sum), .state_o(a_st)
  );

  fir_coeff_loader #(.ORD(255), .M(8), .COEFF_SIZE(CW), .WR_GAP(3)) u_dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .s(ifb),
    .c_we(b_we), .c_wr(b_wr), .c_in(b_cin), .c_addr(b_addr), .busy(b_busy),
    .done(b_done), .err(b_err), .checksum(b_sum), .state_o(b_st)
  );

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [AW+CW-1:0] exp_a[$];
  logic [AW+CW-1:0] exp_b[$];
  logic [AW+CW-1:0] e_a, e_b;
  int wr_a = 0, wr_b = 0;
  logic [AW-1:0] exp_addr_a;
  logic [CW-1:0] sum_a;

  always @(negedge clk) begin
    if (a_wr === 1'b1) begin
      wr_a++;
      total++;
      if (exp_a.size() == 0) begin
        bad++;
        $display("FAIL a_write_unexpected got addr=%0d data=%h, required no write", a_addr, a_cin);
      end else begin
        e_a = exp_a.pop_front();
        if ({a_addr, a_cin} !== e_a)
          begin bad++; $display("FAIL a_write got addr=%0d data=%h required addr=%0d data=%h", a_addr, a_cin, e_a[AW+CW-1:CW], e_a[CW-1:0]); end
      end
      total++;
      if (a_we !== 1'b1) begin bad++; $display("FAIL a_we_with_wr got %b required 1", a_we); end
    end
  end

  always @(negedge clk) begin
    if (b_wr === 1'b1) begin
      wr_b++;
      total++;
      if (exp_b.size() == 0) begin
        bad++;
        $display("FAIL b_write_unexpected got addr=%0d data=%h, required no write", b_addr, b_cin);
      end else begin
        e_b = exp_b.pop_front();
        if ({b_addr, b_cin} !== e_b)
          begin bad++; $display("FAIL b_write got addr=%0d data=%h required addr=%0d data=%h", b_addr, b_cin, e_b[AW+CW-1:CW], e_b[CW-1:0]); end
      end
    end
  end

  // driver tasks (entered and left on a falling edge)
  task automatic send_a(input logic [CW-1:0] d, input logic last, input bit wr);
    int guard;
    guard = 0;
    ifa.s_valid = 1'b1;
    ifa.s_data  = d;
    ifa.s_last  = last;
    while (ifa.s_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      total++; bad++;
      $display("FAIL a_ready_timeout got ready=%b required 1 within 20 cycles", ifa.s_ready);
    end else if (wr) begin
      exp_a.push_back({exp_addr_a, d});
      exp_addr_a++;
      sum_a += d;
    end
    @(negedge clk);
    ifa.s_valid = 1'b0;
    ifa.s_last  = 1'b0;
  endtask

  task automatic start_a();
    exp_addr_a = '0;
    sum_a      = '0;
    wr_a       = 0;
    a_start    = 1'b1;
    @(negedge clk);
    a_start    = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({a_we, a_wr, a_busy, a_done, a_err, a_cin, a_addr, a_sum, ifa.s_ready} !== '0)
      begin bad++; $display("FAIL reset_outputs_a got we=%b wr=%b busy=%b done=%b err=%b sum=%h required all 0", a_we, a_wr, a_busy, a_done, a_err, a_sum); end
    total++;
    if ({b_we, b_wr, b_busy, b_done, b_err, b_cin, b_addr, b_sum, ifb.s_ready} !== '0)
      begin bad++; $display("FAIL reset_outputs_b got we=%b busy=%b done=%b err=%b required all 0", b_we, b_busy, b_done, b_err); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (a_st !== ST_IDLE || b_st !== ST_IDLE)
      begin bad++; $display("FAIL reset_state got a=%0d b=%0d required %0d", a_st, b_st, ST_IDLE); end
  endtask

  task automatic test_full_load();
    start_a();
    total++;
    if (a_st !== ST_LOAD || a_we !== 1'b1)
      begin bad++; $display("FAIL full_enter_load got state=%0d we=%b required %0d/1", a_st, a_we, ST_LOAD); end
    for (int i = 0; i < NL; i++) send_a(CW'(i + 1), (i == NL - 1), 1'b1);
    total++;
    if (a_we !== 1'b1) begin bad++; $display("FAIL full_we_at_last_write got %b required 1", a_we); end
    @(negedge clk);
    total++;
    if (a_we !== 1'b1 || a_done !== 1'b0)
      begin bad++; $display("FAIL full_flush got we=%b done=%b required 1/0", a_we, a_done); end
    @(negedge clk);
    total++;
    if (a_we !== 1'b0 || a_done !== 1'b1 || a_err !== 1'b0 || a_st !== ST_DONE || a_busy !== 1'b0)
      begin bad++; $display("FAIL full_status got we=%b done=%b err=%b state=%0d required 0/1/0/%0d", a_we, a_done, a_err, a_st, ST_DONE); end
    total++;
    if (a_sum !== 16'h2040) begin bad++; $display("FAIL full_checksum got %h required 2040", a_sum); end
    total++;
    if (wr_a !== NL || exp_a.size() != 0)
      begin bad++; $display("FAIL full_write_count got %0d pending=%0d required %0d/0", wr_a, exp_a.size(), NL); end
    total++;
    if (a_addr !== 8'd127 || a_cin !== 16'h0080)
      begin bad++; $display("FAIL full_hold got addr=%0d data=%h required 127/0080", a_addr, a_cin); end
  endtask

  task automatic test_gap();
    int acc, last_cyc, cyc;
    bit spacing_ok, we_ok;
    acc = 0; last_cyc = -1; cyc = 0; spacing_ok = 1'b1; we_ok = 1'b1;
    wr_b = 0;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    ifb.s_valid = 1'b1;
    ifb.s_data  = 16'd1;
    ifb.s_last  = 1'b0;
    while (acc < NL && cyc < 1000) begin
      if (ifb.s_ready === 1'b1) begin
        exp_b.push_back({AW'(acc), ifb.s_data});
        if (last_cyc >= 0 && (cyc - last_cyc) != 4) spacing_ok = 1'b0;
        last_cyc = cyc;
        acc++;
      end
      @(negedge clk);
      cyc++;
      if (b_we !== 1'b1) we_ok = 1'b0;
      ifb.s_data = CW'(acc + 1);
      ifb.s_last = (acc == NL - 1);
    end
    ifb.s_valid = 1'b0;
    ifb.s_last  = 1'b0;
    total++;
    if (acc != NL) begin bad++; $display("FAIL gap_accept_timeout got %0d words required %0d", acc, NL); end
    total++;
    if (spacing_ok !== 1'b1) begin bad++; $display("FAIL gap_ready_duty got irregular spacing required 1-in-4"); end
    total++;
    if (we_ok !== 1'b1) begin bad++; $display("FAIL gap_we_continuous got a low c_we cycle required continuous 1"); end
    repeat (2) @(negedge clk);
    total++;
    if (b_we !== 1'b0 || b_done !== 1'b1 || b_err !== 1'b0 || b_sum !== 16'h2040)
      begin bad++; $display("FAIL gap_status got we=%b done=%b err=%b sum=%h required 0/1/0/2040", b_we, b_done, b_err, b_sum); end
    total++;
    if (wr_b !== NL || exp_b.size() != 0)
      begin bad++; $display("FAIL gap_write_count got %0d pending=%0d required %0d/0", wr_b, exp_b.size(), NL); end
  endtask

  task automatic test_short();
    start_a();
    for (int i = 0; i < 50; i++) send_a(CW'($urandom_range(0, 65535)), (i == 49), 1'b1);
    total++;
    if (a_we !== 1'b1) begin bad++; $display("FAIL short_we_at_write got %b required 1", a_we); end
    @(negedge clk);
    total++;
    if (a_we !== 1'b1) begin bad++; $display("FAIL short_we_plus1 got %b required 1", a_we); end
    @(negedge clk);
    total++;
    if (a_we !== 1'b0 || a_err !== 1'b1 || a_done !== 1'b0 || a_st !== ST_IDLE)
      begin bad++; $display("FAIL short_status got we=%b err=%b done=%b state=%0d required 0/1/0/%0d", a_we, a_err, a_done, a_st, ST_IDLE); end
    total++;
    if (wr_a !== 50 || a_sum !== sum_a)
      begin bad++; $display("FAIL short_count_sum got %0d/%h required 50/%h", wr_a, a_sum, sum_a); end
  endtask

  task automatic test_overlong();
    start_a();
    for (int i = 0; i < NL; i++) send_a(CW'($urandom_range(0, 65535)), 1'b0, 1'b1);
    send_a(16'hAAAA, 1'b0, 1'b0);
    total++;
    if (a_st !== ST_DRAIN || a_we !== 1'b0 || ifa.s_ready !== 1'b1 || a_err !== 1'b1)
      begin bad++; $display("FAIL over_drain got state=%0d we=%b ready=%b err=%b required %0d/0/1/1", a_st, a_we, ifa.s_ready, a_err, ST_DRAIN); end
    send_a(16'h5555, 1'b1, 1'b0);
    total++;
    if (a_st !== ST_IDLE || a_err !== 1'b1 || a_done !== 1'b0 || a_we !== 1'b0)
      begin bad++; $display("FAIL over_status got state=%0d err=%b done=%b we=%b required %0d/1/0/0", a_st, a_err, a_done, a_we, ST_IDLE); end
    total++;
    if (wr_a !== NL || a_sum !== sum_a)
      begin bad++; $display("FAIL over_count_sum got %0d/%h required %0d/%h", wr_a, a_sum, NL, sum_a); end
  endtask

  task automatic test_abort();
    start_a();
    for (int i = 0; i < 20; i++) send_a(CW'($urandom_range(0, 65535)), 1'b0, 1'b1);
    ifa.s_valid = 1'b1;
    ifa.s_data  = 16'hBEEF;
    a_abort     = 1'b1;
    @(negedge clk);
    a_abort     = 1'b0;
    ifa.s_valid = 1'b0;
    total++;
    if (a_we !== 1'b0 || ifa.s_ready !== 1'b0 || a_err !== 1'b1 || a_st !== ST_IDLE)
      begin bad++; $display("FAIL abort_status got we=%b ready=%b err=%b state=%0d required 0/0/1/%0d", a_we, ifa.s_ready, a_err, a_st, ST_IDLE); end
    @(negedge clk);
    total++;
    if (wr_a !== 20 || a_addr !== 8'd19 || a_sum !== sum_a)
      begin bad++; $display("FAIL abort_writes got %0d addr=%0d sum=%h required 20/19/%h", wr_a, a_addr, a_sum, sum_a); end
    // start and abort together in IDLE: abort wins
    a_start = 1'b1;
    a_abort = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_abort = 1'b0;
    total++;
    if (a_st !== ST_IDLE || a_busy !== 1'b0)
      begin bad++; $display("FAIL start_abort got state=%0d busy=%b required %0d/0", a_st, a_busy, ST_IDLE); end
  endtask

  task automatic test_reset_midload();
    start_a();
    for (int i = 0; i < 10; i++) send_a(CW'($urandom_range(0, 65535)), 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({a_we, a_wr, a_busy, a_done, a_err, a_cin, a_addr, a_sum, ifa.s_ready} !== '0)
      begin bad++; $display("FAIL midreset_outputs got we=%b busy=%b err=%b addr=%0d sum=%h required all 0", a_we, a_busy, a_err, a_addr, a_sum); end
    rst = 1'b0;
    @(negedge clk);
    start_a();
    for (int i = 0; i < 5; i++) send_a(CW'($urandom_range(0, 65535)), 1'b0, 1'b1);
    a_start = 1'b1;  // ignored while busy
    @(negedge clk);
    a_start = 1'b0;
    total++;
    if (a_st !== ST_LOAD || a_addr !== 8'd4)
      begin bad++; $display("FAIL start_while_busy got state=%0d addr=%0d required %0d/4", a_st, a_addr, ST_LOAD); end
    for (int i = 5; i < NL; i++) send_a(CW'($urandom_range(0, 65535)), (i == NL - 1), 1'b1);
    repeat (2) @(negedge clk);
    total++;
    if (a_done !== 1'b1 || a_err !== 1'b0 || wr_a !== NL || a_sum !== sum_a)
      begin bad++; $display("FAIL reload_status got done=%b err=%b writes=%0d sum=%h required 1/0/%0d/%h", a_done, a_err, wr_a, a_sum, NL, sum_a); end
  endtask

  initial begin
    ifa.s_valid = 1'b0; ifa.s_data = '0; ifa.s_last = 1'b0;
    ifb.s_valid = 1'b0; ifb.s_data = '0; ifb.s_last = 1'b0;
    exp_addr_a = '0;
    sum_a      = '0;
    test_reset();
    test_full_load();
    test_gap();
    test_short();
    test_overlong();
    test_abort();
    test_reset_midload();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no completion required finish before time limit");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
